note_sequencer: RTL and testbench

- Chart sequencer sitting directly upstream of the note-pattern ROM (4-lane, 1-cycle registered read).
- Steps the ROM address at a fixed tempo, consumes the returned 4-bit lane pattern and emits one-cycle per-lane spawn pulses to the falling-note renderer.
- Provides start, pause, end-of-song status and the current song position for the score and display logic.

---
 rtl/note_sequencer_pkg.sv | 15 +
 rtl/note_sequencer_step_timer.sv | 31 +++
 rtl/note_sequencer.sv | 99 +++++++++
 tb/tb_note_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared chart constants and sequencer state encoding.
// Reused by the sequencer, renderer and hit-judge.
package note_sequencer_pkg;

  localparam int LANES    = 4;
  localparam int ADDR_W   = 13;
  localparam int SONG_LEN = 274;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/note_sequencer_step_timer.sv
// Pausable modulo-N step timer.
// Ports: clk, reset, clear, en in; fetch (count==1), wrap (count==N-1) out.
module step_timer #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic fetch,
  output logic wrap
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  // count==1 means the ROM word for the current address has landed
  assign fetch = (count == W'(1));
  assign wrap  = (count == W'(N - 1));

endmodule

// File: rtl/note_sequencer.sv
// Chart sequencer: steps the note ROM at a fixed tempo, emits lane spawns.
// Ports: clk, reset, start, pause, rom_data in; rom_addr, spawn,
// step_strobe, song_pos, playing, done out.
module note_sequencer #(
  parameter int TICKS_PER_STEP = 12500000,
  parameter int SONG_LEN       = note_sequencer_pkg::SONG_LEN,
  parameter int ADDR_W         = note_sequencer_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             pause,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [note_sequencer_pkg::LANES-1:0] rom_data,
  output logic [note_sequencer_pkg::LANES-1:0] spawn,
  output logic                             step_strobe,
  output logic [ADDR_W-1:0]                song_pos,
  output logic                             playing,
  output logic                             done
);

  import note_sequencer_pkg::*;

  state_t state, state_nx;

  logic [ADDR_W-1:0] idx;
  logic go;
  logic en;
  logic last;
  logic fetch;
  logic wrap;

  // start is only honoured outside PLAY
  assign go   = (state != PLAY) && start;
  assign en   = (state == PLAY) && !pause;
  assign last = (idx == ADDR_W'(SONG_LEN - 1));

  step_timer #(
    .N(TICKS_PER_STEP)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(go),
    .en   (en),
    .fetch(fetch),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = PLAY;
      PLAY: if (en && wrap && last) state_nx = DONE;
      DONE: if (start) state_nx = PLAY;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    playing = (state == PLAY);
    done    = (state == DONE);
  end

  // idx doubles as the ROM address register; it holds at the
  // last step so the final address stays visible in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      spawn       <= '0;
      step_strobe <= 1'b0;
    end else begin
      spawn       <= '0;
      step_strobe <= 1'b0;
      if (go) begin
        idx <= '0;
      end else if (en) begin
        if (fetch) begin
          spawn       <= rom_data;
          step_strobe <= 1'b1;
        end
        if (wrap && !last) begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign rom_addr = idx;
  assign song_pos = idx;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a 4-tick step.
// Event-count reference model plus directed corner sequences.
module tb_note_sequencer;

  localparam int T  = 4;
  localparam int SL = 274;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_data = 4'd0;
  logic [3:0]    spawn;
  logic          step_strobe;
  logic [AW-1:0] song_pos;
  logic          playing;
  logic          done;

  logic [3:0] rom [SL];

  int cmp  = 0;
  int fail = 0;
  int e    = 0;
  int scnt = 0;

  // reference model: counts unpaused PLAY edges since start
  int         m_u    = 0;
  bit         m_play = 0;
  bit         m_done = 0;
  logic [3:0] m_sp   = 4'd0;
  bit         m_st   = 0;
  int         m_pos  = 0;

  typedef struct {
    int         off;
    logic [3:0] sp;
  } vec_t;

  vec_t tv [9];

  note_sequencer #(
    .TICKS_PER_STEP(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .spawn      (spawn),
    .step_strobe(step_strobe),
    .song_pos   (song_pos),
    .playing    (playing),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= (int'(rom_addr) < SL) ? rom[rom_addr] : 4'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit p);
    if (r) begin
      m_play = 0; m_done = 0; m_u = 0;
      m_pos = 0; m_sp = 4'd0; m_st = 0;
    end else if (!m_play && s) begin
      m_play = 1; m_done = 0; m_u = 0;
      m_pos = 0; m_sp = 4'd0; m_st = 0;
    end else if (m_play && !p) begin
      m_u++;
      m_st = ((m_u % T) == 2);
      m_sp = m_st ? rom[(m_u - 2) / T] : 4'd0;
      m_pos = (m_u / T < SL) ? m_u / T : SL - 1;
      if (m_u == T * SL) begin
        m_play = 0;
        m_done = 1;
      end
    end else begin
      m_sp = 4'd0;
      m_st = 0;
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit p);
    reset = r;
    start = s;
    pause = p;
    @(posedge clk);
    model(r, s, p);
    e++;
    @(negedge clk);
    if (step_strobe) scnt++;
    chk("spawn", spawn, m_sp);
    chk("strobe", step_strobe, m_st);
    chk("song_pos", song_pos, m_pos);
    chk("rom_addr", rom_addr, m_pos);
    chk("playing", playing, m_play);
    chk("done", done, m_done);
  endtask

  initial begin
    int g;
    int nz;
    logic [3:0] prev;

    for (int i = 0; i < SL; i++)
      rom[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    rom[0] = 4'b0000; rom[1] = 4'b0000;
    rom[2] = 4'b0000; rom[3] = 4'b0000;
    rom[4] = 4'b1000; rom[5] = 4'b0100;
    rom[6] = 4'b0010; rom[7] = 4'b0001;
    rom[8] = 4'b0011;

    for (int k = 0; k < 9; k++) begin
      tv[k].off = 2 + k * T;
      tv[k].sp  = rom[k];
    end

    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_spawn", spawn, 0);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);

    // first steps from a clean start
    scnt = 0;
    tick(0, 1, 0);
    e = 0;
    chk("e0_playing", playing, 1);
    for (int i = 0; i < 9; i++) begin
      while (e < tv[i].off) tick(0, 0, 0);
      chk("t1_spawn", spawn, tv[i].sp);
      chk("t1_strobe", step_strobe, 1);
    end

    // run the whole song out
    while (!done && e < T * SL + 20) tick(0, 0, 0);
    chk("t2_done_edge", e, T * SL);
    chk("t2_strobes", scnt, SL);
    chk("t2_addr", rom_addr, SL - 1);
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      if (spawn != 0 || step_strobe) nz++;
    end
    chk("t2_quiet", nz, 0);

    // restart from DONE
    tick(0, 1, 0);
    e = 0;
    chk("t5_done", done, 0);
    chk("t5_playing", playing, 1);
    chk("t5_addr", rom_addr, 0);

    // pause straddling step 4's fetch edge
    while (e < 17) tick(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1);
      chk("t3_pos_hold", song_pos, 4);
      chk("t3_no_strobe", step_strobe, 0);
    end
    tick(0, 0, 0);
    chk("t3_spawn4", spawn, 4'b1000);
    chk("t3_strobe4", step_strobe, 1);
    for (int i = 0; i < T; i++) tick(0, 0, 0);
    chk("t3_spawn5", spawn, 4'b0100);

    // start during PLAY is ignored
    g = 0;
    while (song_pos != 10 && g < 200) begin tick(0, 0, 0); g++; end
    chk("t5_reach10", song_pos, 10);
    tick(0, 1, 0);
    chk("t5_still_play", playing, 1);
    prev = 4'd0;
    for (int n = 11; n <= 12; n++) begin
      g = 0;
      while (song_pos == AW'(n - 1) && g < 20) begin tick(0, 0, 0); g++; end
      chk("t5_pos_next", song_pos, n);
    end

    // reset mid-song
    g = 0;
    while (song_pos != 50 && g < 400) begin tick(0, 0, 0); g++; end
    chk("t4_reach50", song_pos, 50);
    tick(1, 0, 0);
    chk("t4_addr", rom_addr, 0);
    chk("t4_pos", song_pos, 0);
    chk("t4_spawn", spawn, 0);
    chk("t4_playing", playing, 0);
    chk("t4_done", done, 0);
    tick(0, 1, 0);
    e = 0;
    while (e < 2 + 4 * T) tick(0, 0, 0);
    chk("t4_replay", spawn, 4'b1000);

    // start with pause held from IDLE
    tick(1, 0, 0);
    tick(0, 1, 1);
    chk("t6_playing", playing, 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1);
      chk("t6_hold_strobe", step_strobe, 0);
      chk("t6_hold_pos", song_pos, 0);
    end
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("t6_empty_strobe", step_strobe, 1);
    chk("t6_empty_spawn", spawn, 0);

    // randomized pause / start / reset traffic
    tick(0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end

endmodule
